// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp sequencer: moves duty_o one LSB toward a host target every
// (rate+1) PWM periods, with updates aligned to period_tick.
module pwm_ramp_ctrl #(
    parameter int WIDTH  = 8,
    parameter int RATE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              period_tick,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WIDTH-1:0]  cfg_target,
    input  logic [RATE_W-1:0] cfg_rate,
    output logic [WIDTH-1:0]  duty_o,
    output logic              duty_upd,
    output logic              busy,
    output logic              done
);

    // state | meaning
    // IDLE  | disabled, duty forced to 0, no config accepted
    // HOLD  | duty static at target, waiting for a new config
    // UP    | ramping duty up one LSB per (rate+1) period ticks
    // DOWN  | ramping duty down one LSB per (rate+1) period ticks
    typedef enum logic [1:0] {IDLE, HOLD, UP, DOWN} state_t;

    state_t              state, state_n;
    logic [WIDTH-1:0]    target, target_n;
    logic [RATE_W-1:0]   rate, rate_n;
    logic [RATE_W-1:0]   step_cnt, step_cnt_n;
    logic [WIDTH-1:0]    duty_n;
    logic [WIDTH-1:0]    duty_step;
    logic                upd_n, done_n;
    logic                accept;

    assign cfg_ready = (state != IDLE);
    assign busy      = (state == UP) || (state == DOWN);
    // A config offered while en is dropping is discarded along with the ramp.
    assign accept    = cfg_valid && cfg_ready && en;
    assign duty_step = (state == UP) ? duty_o + 1'b1 : duty_o - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            duty_o   <= '0;
            target   <= '0;
            rate     <= '0;
            step_cnt <= '0;
            duty_upd <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            duty_o   <= duty_n;
            target   <= target_n;
            rate     <= rate_n;
            step_cnt <= step_cnt_n;
            duty_upd <= upd_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        duty_n     = duty_o;
        target_n   = target;
        rate_n     = rate;
        step_cnt_n = step_cnt;
        upd_n      = 1'b0;
        done_n     = 1'b0;

        if (!en) begin
            state_n    = IDLE;
            duty_n     = '0;
            target_n   = '0;
            step_cnt_n = '0;
        end else if (state == IDLE) begin
            state_n    = HOLD;
            duty_n     = '0;
            step_cnt_n = '0;
        end else if (accept) begin
            // Accept wins over a coincident step; direction from present duty.
            target_n   = cfg_target;
            rate_n     = cfg_rate;
            step_cnt_n = '0;
            if (cfg_target > duty_o) begin
                state_n = UP;
            end else if (cfg_target < duty_o) begin
                state_n = DOWN;
            end else begin
                state_n = HOLD;
                done_n  = 1'b1;
            end
        end else if (busy && period_tick) begin
            if (step_cnt != rate) begin
                step_cnt_n = step_cnt + 1'b1;
            end else begin
                step_cnt_n = '0;
                duty_n     = duty_step;
                upd_n      = 1'b1;
                if (duty_step == target) begin
                    state_n = HOLD;
                    done_n  = 1'b1;
                end
            end
        end else if (!busy) begin
            step_cnt_n = '0;
        end
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Sequencer that drives the 8-bit duty value of the team's PWM generator.
- Ramps the duty from its current value to a host-requested target, one LSB per programmable number of PWM periods. This gives soft-start and fade, with no abrupt duty jumps.
- Host configuration uses a valid/ready handshake.
- Duty updates are aligned to the PWM period boundary (`period_tick` from the generator's prescaler/duty counter), so the PWM output never glitches mid-period.

Parameters:
- WIDTH, 8, duty width; matches the PWM generator compare width.
- RATE_W, 4, width of the periods-per-step field.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  block enable; low forces IDLE.
- period_tick  input  1  one-clk pulse from the PWM generator at the start of each PWM period.
- cfg_valid  input  1  host offers a new target/rate.
- cfg_ready  output  1  block can accept a config; equals en registered (high in HOLD, UP, DOWN).
- cfg_target  input  WIDTH  requested final duty.
- cfg_rate  input  RATE_W  number of PWM periods per step, minus one (0 = step every period).
- duty_o  output  WIDTH  duty value fed to the PWM compare.
- duty_upd  output  1  one-clk pulse in the cycle `duty_o` changes.
- busy  output  1  high in UP or DOWN.
- done  output  1  one-clk pulse when `duty_o` reaches the target.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - duty_o = 0, target = 0, rate = 0, step_cnt = 0.
  - cfg_ready = 0, duty_upd = 0, busy = 0, done = 0.
- States: IDLE, HOLD, UP, DOWN.
- IDLE:
  - duty_o = 0, cfg_ready = 0.
  - en high -> HOLD on the next clk.
- Handshake:
  - A config is accepted when cfg_valid && cfg_ready in the same cycle.
  - On accept, cfg_target and cfg_rate are captured into target and rate, and step_cnt is cleared.
  - Next state, evaluated in the accept cycle against the current duty_o: target > duty_o -> UP; target < duty_o -> DOWN; equal -> HOLD with done pulsed on the next clk.
  - Accepts are allowed in UP and DOWN (retarget mid-ramp). The direction is recomputed from the present duty_o.
- Stepping (UP/DOWN), evaluated on period_tick only:
  - If step_cnt != rate: step_cnt += 1.
  - Otherwise: step_cnt = 0, duty_o ±= 1, duty_upd = 1.
  - If the new duty_o equals target: state -> HOLD and done = 1, both in the same clk the update takes effect.
- Latency:
  - duty_o changes 1 clk after the qualifying period_tick (registered).
  - The first step occurs on the (rate+1)-th period_tick after accept.
  - Total ramp = |target − duty| × (rate+1) period_ticks.
- Arithmetic:
  - Unsigned WIDTH-bit values.
  - The ramp stops exactly at target, so wrap-around is impossible. No step may take duty_o past 0 or 2^WIDTH−1.
- Simultaneous events:
  - Accept and qualifying period_tick in the same cycle: the accept wins, the step is suppressed, and step_cnt is cleared.
  - Accept with target equal to the current duty while in UP/DOWN: -> HOLD, done pulse.
- en deassert (any state):
  - Next clk: IDLE, duty_o = 0 (immediate; the PWM is off), target cleared, busy/done low, cfg_ready low.
  - A pending cfg_valid is not accepted.
- period_tick while in HOLD or IDLE: ignored; step_cnt is held at 0.
- done and duty_upd are strictly single-cycle pulses.

Test Plan:
1. Reset, en = 1, accept target = 5, rate = 0, period_tick every 10 clk -> duty_o = 1, 2, 3, 4, 5 on successive ticks, 5 duty_upd pulses, done with the final update, busy low afterwards, cfg_ready high throughout.
2. From duty = 5, accept target = 2, rate = 2 -> DOWN; duty_o decrements on the 3rd, 6th and 9th ticks, ending at 2; done pulses once.
3. Mid-ramp retarget: ramping 0→200 at rate = 0; at duty = 50 accept target = 40 -> state DOWN, duty reaches 40 after 10 ticks; no overshoot beyond 50.
4. Accept coinciding with a qualifying period_tick -> duty_o is unchanged that cycle, step_cnt = 0; the next step comes rate+1 ticks later.
5. Boundary: ramp to 255 and then to 0 at rate = 0 -> duty_o stops at 255 and at 0 with no wrap; an accept of target = current duty gives done on the next clk and no duty_upd.
6. Drop en mid-ramp at duty = 30 -> next clk duty_o = 0, IDLE, cfg_ready = 0. Assert rst_n low asynchronously mid-ramp -> outputs go to zero immediately without a clock edge.
